// File: rtl/systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_array_ctrl
//   Sequencer for a DIMENSION x DIMENSION systolic multiply-accumulate array.
//   On i_start it reads one A column and one B row per cycle from an external
//   buffer. It skews them onto the left and top array edges, together with a
//   skewed array reset. It captures every PE result in that PE's single
//   finish cycle, then streams C = A*B out row-major over valid/ready.
//
// Ports
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_start                  start request (sampled only when idle)
//   o_busy                   high whenever not idle
//   o_rd_en, o_rd_k          operand read request; data returns 1 cycle later
//   i_a_col, i_b_row         A[i][k] on lane i, B[k][j] on lane j
//   o_a_edge, o_b_edge       skewed operands to PE(i,0).i_a / PE(0,j).i_b
//   o_a_reset, o_b_reset     skewed array reset to the same edge PEs
//   i_c_flat, i_finish       per-PE result and finish flag, PE index i*D+j
//   o_res_valid/data/idx     result stream, held while stalled
//   i_res_ready              result beat accepted when valid && ready
//   o_done                   one-cycle pulse after the last accepted beat
//   o_err                    sticky missing-finish flag, cleared on start
// -----------------------------------------------------------------------------
module systolic_array_ctrl #(
  parameter int DIMENSION = 4,
  parameter int I_BITS    = 8,
  parameter int O_BITS    = 2 * I_BITS + $clog2(DIMENSION)
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset,
  input  logic                                      i_start,
  output logic                                      o_busy,
  output logic                                      o_rd_en,
  output logic [$clog2(DIMENSION)-1:0]              o_rd_k,
  input  logic [DIMENSION*I_BITS-1:0]               i_a_col,
  input  logic [DIMENSION*I_BITS-1:0]               i_b_row,
  output logic [DIMENSION*I_BITS-1:0]               o_a_edge,
  output logic [DIMENSION*I_BITS-1:0]               o_b_edge,
  output logic [DIMENSION-1:0]                      o_a_reset,
  output logic [DIMENSION-1:0]                      o_b_reset,
  input  logic [DIMENSION*DIMENSION*O_BITS-1:0]     i_c_flat,
  input  logic [DIMENSION*DIMENSION-1:0]            i_finish,
  output logic                                      o_res_valid,
  output logic [O_BITS-1:0]                         o_res_data,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0]    o_res_idx,
  input  logic                                      i_res_ready,
  output logic                                      o_done,
  output logic                                      o_err
);

  localparam int D  = DIMENSION;
  localparam int KW = $clog2(D);
  localparam int IW = $clog2(D * D);
  localparam int TW = $clog2(3 * D);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_WAIT, S_DRAIN, S_DONE} state_e;

  state_e                          state_q, state_d;
  logic [TW-1:0]                   t_q, t_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            rd_valid_q;   // read data is on i_a_col/i_b_row
  logic                            start_go;
  logic                            arr_rst;      // raw (unskewed) array reset
  logic [D-1:1]                    rst_dly_q;    // bit s = arr_rst delayed s cycles
  logic [D*D-1:0][O_BITS-1:0]      cap_q;
  logic [D*D-1:0]                  mask_q;
  logic                            err_q;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers update from the same pre-edge values regardless of block order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      rst_dly_q  <= '0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      idx_q        <= idx_d;
      rd_valid_q   <= o_rd_en;
      rst_dly_q[1] <= arr_rst;
      for (int s = 2; s < D; s++) rst_dly_q[s] <= rst_dly_q[s-1];
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    idx_d       = idx_q;
    start_go    = 1'b0;
    arr_rst     = 1'b0;
    o_busy      = 1'b1;
    o_rd_en     = 1'b0;
    o_rd_k      = '0;
    o_res_valid = 1'b0;
    o_res_data  = '0;
    o_res_idx   = '0;
    o_done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          start_go = 1'b1;
          state_d  = S_FEED;
          t_d      = '0;
        end
      end
      S_FEED: begin
        o_rd_en = 1'b1;
        o_rd_k  = t_q[KW-1:0];
        arr_rst = (t_q == '0);
        t_d     = t_q + TW'(1);
        if (t_q == TW'(D - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        t_d = t_q + TW'(1);
        if (t_q == TW'(3 * D - 1)) begin
          state_d = S_DRAIN;
          t_d     = '0;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        o_res_valid = 1'b1;
        o_res_idx   = idx_q;
        o_res_data  = mask_q[idx_q] ? cap_q[idx_q] : '0;
        if (i_res_ready) begin
          if (idx_q == IW'(D * D - 1)) state_d = S_DONE;
          else                         idx_d   = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The array reset for row i / column j is the raw pulse delayed i / j cycles;
  // the PE-to-PE hop adds the rest, so PE(i,j) sees reset at t = i+j.
  assign o_a_reset = {rst_dly_q, arr_rst};
  assign o_b_reset = {rst_dly_q, arr_rst};

  // ---------------------------------------------------------------------------
  // Operand skew: lane n is delayed n cycles; lane 0 passes straight through.
  // Lanes are forced to 0 whenever no read data is returning.
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < D; n++) begin : g_lane
    logic [I_BITS-1:0] a_in, b_in;
    assign a_in = rd_valid_q ? i_a_col[n*I_BITS +: I_BITS] : '0;
    assign b_in = rd_valid_q ? i_b_row[n*I_BITS +: I_BITS] : '0;

    if (n == 0) begin : g_pass
      assign o_a_edge[0 +: I_BITS] = a_in;
      assign o_b_edge[0 +: I_BITS] = b_in;
    end else begin : g_dly
      logic [n-1:0][I_BITS-1:0] a_pipe_q, b_pipe_q;
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          a_pipe_q <= '0;
          b_pipe_q <= '0;
        end else begin
          a_pipe_q[0] <= a_in;
          b_pipe_q[0] <= b_in;
          for (int s = 1; s < n; s++) begin
            a_pipe_q[s] <= a_pipe_q[s-1];
            b_pipe_q[s] <= b_pipe_q[s-1];
          end
        end
      end
      assign o_a_edge[n*I_BITS +: I_BITS] = a_pipe_q[n-1];
      assign o_b_edge[n*I_BITS +: I_BITS] = b_pipe_q[n-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture: PE(i,j) is sampled only at t = i+j+D+1, its finish cycle.
  // Finish pulses at any other time (e.g. stale pre-reset counters) are ignored.
  // ---------------------------------------------------------------------------
  // NOTE: the capture buffer is reset along with the control state so that no
  // data from an aborted run can ever appear on o_res_data.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cap_q  <= '0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_go) begin
        mask_q <= '0;
        err_q  <= 1'b0;
      end
      if (state_q == S_FEED || state_q == S_WAIT) begin
        for (int i = 0; i < D; i++) begin
          for (int j = 0; j < D; j++) begin
            if (t_q == TW'(i + j + D + 1)) begin
              cap_q[i*D+j]  <= i_c_flat[(i*D+j)*O_BITS +: O_BITS];
              mask_q[i*D+j] <= 1'b1;
              if (!i_finish[i*D+j]) err_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_ctrl
//   Directed bench for systolic_array_ctrl (D=4, I_BITS=8, O_BITS=18).
//   The bench plays the operand buffer and the PE array: each PE presents its
//   hand-computed result and finish flag only in its own capture cycle and
//   junk otherwise. A table of operand sets is run in a loop, followed by
//   hand-written sequences for mid-run reset and back-to-back starts.
// -----------------------------------------------------------------------------
module tb_systolic_array_ctrl;

  localparam int D  = 4;
  localparam int IB = 8;
  localparam int OB = 18;
  localparam int NT = 5;

  typedef struct packed {
    logic [D*D*IB-1:0] a;         // A[i][k] at (i*D+k)*IB
    logic [D*D*IB-1:0] b;         // B[k][j] at (k*D+j)*IB
    logic [D*D*OB-1:0] c;         // expected C[i][j] at (i*D+j)*OB
    logic [3:0]        rdy;       // i_res_ready pattern, msb first
    logic              drop;      // withhold one PE finish at its slot
    logic [3:0]        drop_idx;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 i_reset, i_start, i_res_ready;
  logic                 o_busy, o_rd_en, o_res_valid, o_done, o_err;
  logic [1:0]           o_rd_k;
  logic [D*IB-1:0]      i_a_col, i_b_row, o_a_edge, o_b_edge;
  logic [D-1:0]         o_a_reset, o_b_reset;
  logic [D*D*OB-1:0]    i_c_flat;
  logic [D*D-1:0]       i_finish;
  logic [OB-1:0]        o_res_data;
  logic [3:0]           o_res_idx;

  int   errors = 0;
  int   checks = 0;
  vec_t tv [NT];
  logic       prev_rd_en;
  logic [1:0] prev_rd_k;

  always #5 clk = ~clk;

  systolic_array_ctrl #(.DIMENSION(D), .I_BITS(IB)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .o_busy(o_busy),
    .o_rd_en(o_rd_en), .o_rd_k(o_rd_k), .i_a_col(i_a_col), .i_b_row(i_b_row),
    .o_a_edge(o_a_edge), .o_b_edge(o_b_edge), .o_a_reset(o_a_reset),
    .o_b_reset(o_b_reset), .i_c_flat(i_c_flat), .i_finish(i_finish),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_idx(o_res_idx),
    .i_res_ready(i_res_ready), .o_done(o_done), .o_err(o_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {o_busy, o_rd_en, o_rd_k, o_a_edge, o_b_edge, o_a_reset, o_b_reset,
                 o_res_valid, o_res_data, o_res_idx, o_done, o_err}, '0);
  endtask

  task automatic drive_junk();
    i_a_col  = {D{8'hA5}};
    i_b_row  = {D{8'h5A}};
    i_c_flat = {(D*D){18'h2A5A5}};
    i_finish = '0;
  endtask

  // One full operation. Entered inside an IDLE cycle, before its posedge;
  // returns inside the following IDLE cycle, after checking it.
  task automatic run_op(input int n, input bit b2b);
    vec_t v;
    int   slot_d, exp_idx, cyc;
    logic [D*IB-1:0] exp_a, exp_b;
    v = tv[n];
    slot_d = int'(v.drop_idx[3:2]) + int'(v.drop_idx[1:0]) + D + 1;
    i_start = 1'b1;
    i_res_ready = 1'b0;
    drive_junk();
    prev_rd_en = 1'b0;
    prev_rd_k  = '0;
    for (int t = 0; t < 3 * D; t++) begin
      @(negedge clk);
      i_start = 1'b0;
      drive_junk();
      if (prev_rd_en) begin
        for (int l = 0; l < D; l++) begin
          i_a_col[l*IB +: IB] = v.a[(l*D + int'(prev_rd_k))*IB +: IB];
          i_b_row[l*IB +: IB] = v.b[(int'(prev_rd_k)*D + l)*IB +: IB];
        end
      end
      for (int i = 0; i < D; i++) begin
        for (int j = 0; j < D; j++) begin
          if (t == i + j + D + 1) i_c_flat[(i*D+j)*OB +: OB] = v.c[(i*D+j)*OB +: OB];
          i_finish[i*D+j] = ((t == i + j + D + 1) && !(v.drop && (i*D+j) == int'(v.drop_idx)))
                            || (t < i + j);
        end
      end
      #1;
      exp_a = '0;
      exp_b = '0;
      for (int l = 0; l < D; l++) begin
        if (t - 1 - l >= 0 && t - 1 - l < D) begin
          exp_a[l*IB +: IB] = v.a[(l*D + t - 1 - l)*IB +: IB];
          exp_b[l*IB +: IB] = v.b[((t - 1 - l)*D + l)*IB +: IB];
        end
      end
      check($sformatf("c%0d_t%0d_busy", n, t), o_busy, 1'b1);
      check($sformatf("c%0d_t%0d_rd_en", n, t), o_rd_en, (t < D));
      if (t < D) check($sformatf("c%0d_t%0d_rd_k", n, t), o_rd_k, t);
      check($sformatf("c%0d_t%0d_a_edge", n, t), o_a_edge, exp_a);
      check($sformatf("c%0d_t%0d_b_edge", n, t), o_b_edge, exp_b);
      for (int l = 0; l < D; l++) begin
        check($sformatf("c%0d_t%0d_a_rst%0d", n, t, l), o_a_reset[l], (t == l));
        check($sformatf("c%0d_t%0d_b_rst%0d", n, t, l), o_b_reset[l], (t == l));
      end
      check($sformatf("c%0d_t%0d_valid", n, t), o_res_valid, 1'b0);
      check($sformatf("c%0d_t%0d_err", n, t), o_err, (v.drop && t > slot_d));
      prev_rd_en = o_rd_en;
      prev_rd_k  = o_rd_k;
    end
    // Drain with the case's backpressure pattern.
    exp_idx = 0;
    cyc = 0;
    while (exp_idx < D * D && cyc < 64) begin
      @(negedge clk);
      drive_junk();
      i_res_ready = v.rdy[3 - (cyc % 4)];
      #1;
      check($sformatf("c%0d_d%0d_valid", n, cyc), o_res_valid, 1'b1);
      check($sformatf("c%0d_d%0d_idx", n, cyc), o_res_idx, exp_idx);
      check($sformatf("c%0d_d%0d_data", n, cyc), o_res_data, v.c[exp_idx*OB +: OB]);
      check($sformatf("c%0d_d%0d_done", n, cyc), o_done, 1'b0);
      check($sformatf("c%0d_d%0d_err", n, cyc), o_err, v.drop);
      if (i_res_ready) exp_idx++;
      cyc++;
    end
    check($sformatf("c%0d_drain_bound", n), exp_idx, D * D);
    @(negedge clk);
    i_res_ready = 1'b0;
    i_start = b2b;
    #1;
    check($sformatf("c%0d_done", n), {o_done, o_busy, o_res_valid, o_err}, {1'b1, 1'b1, 1'b0, v.drop});
    @(negedge clk);
    #1;
    check($sformatf("c%0d_idle", n), {o_done, o_busy, o_rd_en, o_err}, {1'b0, 1'b0, 1'b0, v.drop});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Operand sets with hand-derived products.
    for (int n = 0; n < NT; n++) tv[n] = '0;
    for (int i = 0; i < D; i++) begin
      for (int k = 0; k < D; k++) begin
        // 0: A = I, B[k][j] = 4k+j+1  ->  C[i][j] = 4i+j+1 = idx+1
        tv[0].a[(i*D+k)*IB +: IB] = (i == k) ? 8'd1 : 8'd0;
        tv[0].b[(i*D+k)*IB +: IB] = 8'(i*D + k + 1);
        tv[0].c[(i*D+k)*OB +: OB] = 18'(i*D + k + 1);
        // 1: every operand -128  ->  C = 4 * 16384 = 65536
        tv[1].a[(i*D+k)*IB +: IB] = 8'h80;
        tv[1].b[(i*D+k)*IB +: IB] = 8'h80;
        tv[1].c[(i*D+k)*OB +: OB] = 18'd65536;
        // 3: A all ones  ->  C[i][j] = sum_k (4k+j+1) = 28+4j
        tv[3].a[(i*D+k)*IB +: IB] = 8'd1;
        tv[3].b[(i*D+k)*IB +: IB] = 8'(i*D + k + 1);
        tv[3].c[(i*D+k)*OB +: OB] = 18'(28 + 4*k);
        // 4: A = -I  ->  C = -(idx+1)
        tv[4].a[(i*D+k)*IB +: IB] = (i == k) ? 8'hFF : 8'd0;
        tv[4].b[(i*D+k)*IB +: IB] = 8'(i*D + k + 1);
        tv[4].c[(i*D+k)*OB +: OB] = 18'(-(i*D + k + 1));
      end
    end
    tv[2] = tv[0];
    tv[0].rdy = 4'b1111;
    tv[1].rdy = 4'b1111;
    tv[2].rdy = 4'b1001;          // ready toggles 1,0,0,1
    tv[3].rdy = 4'b1111;
    tv[3].drop = 1'b1;            // PE 5 = (1,1) misses its finish at t=7
    tv[3].drop_idx = 4'd5;
    tv[4].rdy = 4'b1111;

    i_reset = 1'b1;
    i_start = 1'b0;
    i_res_ready = 1'b0;
    drive_junk();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset_outputs");
    i_reset = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("idle_after_reset");

    for (int n = 0; n < NT; n++) run_op(n, 1'b0);

    // Reset in the middle of FEED: idle with all outputs low on the next cycle.
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midreset_pre_rd_k", {o_busy, o_rd_en, o_rd_k}, {1'b1, 1'b1, 2'd2});
    i_reset = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("midreset_outputs");
    i_reset = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("midreset_idle");
    run_op(0, 1'b0);

    // Start held through the DONE cycle (ignored) into IDLE (accepted).
    run_op(1, 1'b1);
    run_op(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
